icap_arbiter: RTL and testbench
===============================

ICAP_ARBITER -- requirements
Module: icap_arbiter

Interface
REQ-001 The block SHALL have parameter REL_TIMEOUT, default 1024, meaning the cycles a holder may keep the grant after rel is asserted before it is revoked.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 2, meaning the idle cycles with icap_csib forced high between two owners.
REQ-003 The block SHALL have parameter PRC_FIRST, default 1, meaning PRC wins a simultaneous first request after reset.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset; the ports SHALL be as follows:
- icap_clk  in  1  sole clock, shared with ICAPE3 and FRAME_ECCE4.
- icap_rst_n  in  1  asynchronous active-low reset.
- sem_req, prc_req  in  1 each  requester wants the ICAP.
- sem_gnt, prc_gnt  out  1 each  requester owns the ICAP.
- sem_rel, prc_rel  out  1 each  holder is asked to release.
- sem_csib, sem_rdwrb, prc_csib, prc_rdwrb  in  1 each  requester ICAP controls.
- sem_i, prc_i  in  32 each  requester ICAP write data.
- icap_csib, icap_rdwrb  out  1 each  to ICAPE3.
- icap_i  out  32  to ICAPE3.
- owner  out  2  00=none, 01=SEM, 10=PRC.
- rel_timeout  out  1  one-cycle pulse on forced revoke.

Function
REQ-005 The FSM SHALL have the states IDLE, OWN_SEM, OWN_PRC, REL_WAIT and GAP.
REQ-006 In IDLE, if exactly one request is high, the FSM SHALL grant that requester on the next edge.
REQ-007 In IDLE with both requests high, the FSM SHALL grant the requester that was not the last owner; with no last owner, it SHALL grant PRC when PRC_FIRST=1, else SEM.
REQ-008 sem_gnt, prc_gnt, sem_rel, prc_rel and owner SHALL be registered; the grant SHALL appear 1 cycle after the IDLE-state request.
REQ-009 icap_csib, icap_rdwrb and icap_i SHALL be a combinational mux of the owner's inputs, selected by the registered owner, adding zero latency.
REQ-010 With owner=none (IDLE, GAP, reset), the outputs SHALL be icap_csib=1, icap_rdwrb=1 and icap_i=0, and the requester inputs SHALL be ignored.
REQ-011 If the holder deasserts req in OWN_x or REL_WAIT, then on the next edge: gnt low, rel low, owner=none, state GAP, last-owner recorded.
REQ-012 If the non-holder's req is high in OWN_x, the FSM SHALL, on the next edge, raise rel to the holder, clear the timeout counter and enter REL_WAIT.
REQ-013 In REL_WAIT, the counter SHALL increment each cycle while the holder keeps req high.
REQ-014 When the counter reaches REL_TIMEOUT-1, the FSM SHALL force a revoke: gnt low, rel low, rel_timeout pulses 1 cycle, state GAP.
REQ-015 If the non-holder withdraws req during REL_WAIT while the holder still requests, rel SHALL drop next cycle, the counter SHALL clear and the FSM SHALL return to OWN_x.
REQ-016 If the holder withdraws in the same cycle as the timeout, the event SHALL be a normal release (REQ-011) with no rel_timeout pulse.
REQ-017 GAP SHALL last exactly GAP_CYCLES cycles, after which the FSM SHALL enter IDLE; a GAP_CYCLES=0 build SHALL go directly to IDLE.
REQ-018 The timeout counter SHALL be clog2(REL_TIMEOUT) bits wide, SHALL saturate rather than wrap, and SHALL be cleared on entry to every state.
REQ-019 gnt SHALL never be high to both requesters; rel SHALL only be high to the current holder.

Reset
REQ-020 Assertion of icap_rst_n SHALL immediately, including mid-grant or mid-REL_WAIT, force: state IDLE, owner=00, all gnt/rel=0, rel_timeout=0, icap_csib=1, icap_rdwrb=1, icap_i=0, counters 0, last-owner none.
REQ-021 The first grant after deassertion SHALL occur no earlier than the second rising edge after deassertion.

Structure
REQ-022 The shared package icap_arb_pkg SHALL hold the state enum, the owner encodings (OWN_NONE/OWN_SEM/OWN_PRC) and the ICAP idle constants.
REQ-023 The block SHALL have a single module with no sub-module.
REQ-024 The block SHALL sit between sem_wrapper (cap_req/cap_gnt/cap_rel) and the PR controller ICAP port.

Verification
REQ-025 SEM-only request: sem_req=1 from idle -> sem_gnt=1 and owner=01 after 1 cycle; sem_i=32'hAA995566 appears on icap_i in the same cycle.
REQ-026 Cooperative handover: with SEM owning, prc_req=1 -> sem_rel=1 next cycle; SEM drops req 5 cycles later -> 2 cycles with icap_csib=1, then prc_gnt=1.
REQ-027 Forced revoke: with REL_TIMEOUT=16 and SEM never dropping req -> sem_gnt falls and rel_timeout pulses exactly 16 cycles after sem_rel rises, then PRC is granted after GAP.
REQ-028 Simultaneous request after reset: both requests high -> PRC granted; after PRC releases with both still high -> SEM granted.
REQ-029 Withdrawal: prc_req pulses for 3 cycles during SEM ownership -> sem_rel high for 3 cycles, then low, SEM retains the grant, and the counter is cleared.
REQ-030 Reset during REL_WAIT: icap_rst_n=0 -> all gnt/rel 0, icap_csib=1 and owner=00 with no clock edge required.

Source files
------------

// File: rtl/icap_arb_pkg.sv
// Shared types and constants for the ICAP arbiter: FSM states, owner
// encodings and the value driven onto ICAPE3 when nobody owns it.
package icap_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_OWN_SEM  = 3'd1,
    ST_OWN_PRC  = 3'd2,
    ST_REL_WAIT = 3'd3,
    ST_GAP      = 3'd4
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_SEM  = 2'b01,
    OWN_PRC  = 2'b10
  } owner_t;

  // One requester's ICAP control bundle.
  typedef struct packed {
    logic        csib;
    logic        rdwrb;
    logic [31:0] data;
  } icap_port_t;

  localparam logic        ICAP_IDLE_CSIB  = 1'b1;
  localparam logic        ICAP_IDLE_RDWRB = 1'b1;
  localparam logic [31:0] ICAP_IDLE_DATA  = 32'h0;
  localparam icap_port_t  ICAP_IDLE       = '{csib: ICAP_IDLE_CSIB, rdwrb: ICAP_IDLE_RDWRB, data: ICAP_IDLE_DATA};

endpackage

// File: rtl/icap_arbiter.sv
// Two-way ICAPE3 arbiter between the SEM wrapper and the PR controller.
// Cooperative release via rel, forced revoke after REL_TIMEOUT cycles, and
// a deselected GAP between owners so ICAPE3 never sees back-to-back owners.
module icap_arbiter
  import icap_arb_pkg::*;
#(
  parameter int REL_TIMEOUT = 1024,
  parameter int GAP_CYCLES  = 2,
  parameter bit PRC_FIRST   = 1'b1
) (
  input  logic        icap_clk,
  input  logic        icap_rst_n,
  input  logic        sem_req,
  input  logic        prc_req,
  output logic        sem_gnt,
  output logic        prc_gnt,
  output logic        sem_rel,
  output logic        prc_rel,
  input  logic        sem_csib,
  input  logic        sem_rdwrb,
  input  logic        prc_csib,
  input  logic        prc_rdwrb,
  input  logic [31:0] sem_i,
  input  logic [31:0] prc_i,
  output logic        icap_csib,
  output logic        icap_rdwrb,
  output logic [31:0] icap_i,
  output logic [1:0]  owner,
  output logic        rel_timeout
);

  localparam int            CW       = (REL_TIMEOUT > 1) ? $clog2(REL_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((REL_TIMEOUT > 0) ? REL_TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam int            GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  // A zero-gap build skips GAP entirely after a release.
  localparam arb_state_t    REL_NEXT = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

  arb_state_t    state_q;
  owner_t        owner_q;
  owner_t        last_q;
  logic [CW-1:0] cnt_q;
  logic [GW-1:0] gap_q;
  logic          arm_q;   // blocks a grant on the first edge after reset
  logic          hold_req;
  logic          other_req;
  logic          pick_prc;
  icap_port_t    icap_port;

  assign hold_req  = (owner_q == OWN_PRC) ? prc_req : sem_req;
  assign other_req = (owner_q == OWN_PRC) ? sem_req : prc_req;
  // On a tie the requester that did not own last wins; fresh from reset PRC_FIRST decides.
  assign pick_prc  = prc_req && (!sem_req || (last_q == OWN_SEM) ||
                                 ((last_q == OWN_NONE) && PRC_FIRST));

  // Arbitration FSM; every handshake output is registered here.
  always_ff @(posedge icap_clk or negedge icap_rst_n) begin
    if (!icap_rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_NONE;
      last_q      <= OWN_NONE;
      sem_gnt     <= 1'b0;
      prc_gnt     <= 1'b0;
      sem_rel     <= 1'b0;
      prc_rel     <= 1'b0;
      rel_timeout <= 1'b0;
      cnt_q       <= '0;
      gap_q       <= '0;
      arm_q       <= 1'b0;
    end else begin
      rel_timeout <= 1'b0;
      cnt_q       <= '0;
      gap_q       <= '0;
      arm_q       <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (arm_q && (sem_req || prc_req)) begin
            if (pick_prc) begin
              state_q <= ST_OWN_PRC;
              owner_q <= OWN_PRC;
              prc_gnt <= 1'b1;
            end else begin
              state_q <= ST_OWN_SEM;
              owner_q <= OWN_SEM;
              sem_gnt <= 1'b1;
            end
          end
        end
        ST_OWN_SEM, ST_OWN_PRC: begin
          if (!hold_req) begin
            state_q <= REL_NEXT;
            last_q  <= owner_q;
            owner_q <= OWN_NONE;
            sem_gnt <= 1'b0;
            prc_gnt <= 1'b0;
          end else if (other_req) begin
            state_q <= ST_REL_WAIT;
            sem_rel <= (owner_q == OWN_SEM);
            prc_rel <= (owner_q == OWN_PRC);
          end
        end
        ST_REL_WAIT: begin
          if (!hold_req) begin
            // Holder let go on its own, even if the timeout hit this cycle.
            state_q <= REL_NEXT;
            last_q  <= owner_q;
            owner_q <= OWN_NONE;
            sem_gnt <= 1'b0;
            prc_gnt <= 1'b0;
            sem_rel <= 1'b0;
            prc_rel <= 1'b0;
          end else if (!other_req) begin
            // Contender withdrew: keep the holder, cancel the release request.
            state_q <= (owner_q == OWN_PRC) ? ST_OWN_PRC : ST_OWN_SEM;
            sem_rel <= 1'b0;
            prc_rel <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q     <= REL_NEXT;
            last_q      <= owner_q;
            owner_q     <= OWN_NONE;
            sem_gnt     <= 1'b0;
            prc_gnt     <= 1'b0;
            sem_rel     <= 1'b0;
            prc_rel     <= 1'b0;
            rel_timeout <= 1'b1;
          end else begin
            cnt_q <= (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_LAST) state_q <= ST_IDLE;
          else                   gap_q   <= gap_q + 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          owner_q <= OWN_NONE;
          sem_gnt <= 1'b0;
          prc_gnt <= 1'b0;
          sem_rel <= 1'b0;
          prc_rel <= 1'b0;
        end
      endcase
    end
  end

  // ICAP mux keyed on the registered owner; idle value whenever nobody owns it.
  always_comb begin
    icap_port = ICAP_IDLE;
    case (owner_q)
      OWN_SEM: icap_port = '{csib: sem_csib, rdwrb: sem_rdwrb, data: sem_i};
      OWN_PRC: icap_port = '{csib: prc_csib, rdwrb: prc_rdwrb, data: prc_i};
      default: icap_port = ICAP_IDLE;
    endcase
  end

  assign icap_csib  = icap_port.csib;
  assign icap_rdwrb = icap_port.rdwrb;
  assign icap_i     = icap_port.data;
  assign owner      = owner_q;

endmodule

// File: tb/tb_icap_arbiter.sv
// Directed bench for icap_arbiter, built with REL_TIMEOUT=16, GAP_CYCLES=2.
module tb_icap_arbiter;

  logic        icap_clk;
  logic        icap_rst_n;
  logic        sem_req, prc_req;
  logic        sem_gnt, prc_gnt, sem_rel, prc_rel;
  logic        sem_csib, sem_rdwrb, prc_csib, prc_rdwrb;
  logic [31:0] sem_i, prc_i;
  logic        icap_csib, icap_rdwrb;
  logic [31:0] icap_i;
  logic [1:0]  owner;
  logic        rel_timeout;

  int checks   = 0;
  int failures = 0;

  icap_arbiter #(.REL_TIMEOUT(16), .GAP_CYCLES(2), .PRC_FIRST(1'b1)) dut (
    .icap_clk(icap_clk), .icap_rst_n(icap_rst_n),
    .sem_req(sem_req), .prc_req(prc_req),
    .sem_gnt(sem_gnt), .prc_gnt(prc_gnt),
    .sem_rel(sem_rel), .prc_rel(prc_rel),
    .sem_csib(sem_csib), .sem_rdwrb(sem_rdwrb),
    .prc_csib(prc_csib), .prc_rdwrb(prc_rdwrb),
    .sem_i(sem_i), .prc_i(prc_i),
    .icap_csib(icap_csib), .icap_rdwrb(icap_rdwrb), .icap_i(icap_i),
    .owner(owner), .rel_timeout(rel_timeout)
  );

  initial icap_clk = 1'b0;
  always #5 icap_clk = ~icap_clk;

  // advance one edge, settle 1 ns past it
  task automatic step;
    @(posedge icap_clk);
    #1;
  endtask

  // reset pulse, then two edges so the arbiter is armed and idle
  task automatic do_reset;
    sem_req = 1'b0; prc_req = 1'b0;
    icap_rst_n = 1'b0;
    step();
    icap_rst_n = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset;
    icap_rst_n = 1'b0;
    sem_req = 1'b1; prc_req = 1'b0;
    sem_csib = 1'b0; sem_rdwrb = 1'b0; sem_i = 32'hAA995566;
    prc_csib = 1'b0; prc_rdwrb = 1'b0; prc_i = 32'h0;
    #3;
    checks++; if (owner !== 2'b00) begin failures++; $display("FAIL reset_owner got=%b exp=00", owner); end
    checks++; if ({sem_gnt, prc_gnt, sem_rel, prc_rel, rel_timeout} !== 5'b0) begin failures++; $display("FAIL reset_handshake got=%b exp=00000", {sem_gnt, prc_gnt, sem_rel, prc_rel, rel_timeout}); end
    checks++; if ({icap_csib, icap_rdwrb} !== 2'b11) begin failures++; $display("FAIL reset_ctrl got=%b exp=11", {icap_csib, icap_rdwrb}); end
    checks++; if (icap_i !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=00000000", icap_i); end
    step();
    icap_rst_n = 1'b1;
    step();
    checks++; if (sem_gnt !== 1'b0) begin failures++; $display("FAIL reset_first_edge_gnt got=%b exp=0", sem_gnt); end
    step();
    checks++; if (sem_gnt !== 1'b1) begin failures++; $display("FAIL reset_second_edge_gnt got=%b exp=1", sem_gnt); end
  endtask

  task automatic test_sem_only;
    do_reset();
    sem_i = 32'hAA995566; sem_csib = 1'b0; sem_rdwrb = 1'b0;
    sem_req = 1'b1;
    #1;
    checks++; if (icap_i !== 32'h0) begin failures++; $display("FAIL sem_only_idle_ignored got=%h exp=00000000", icap_i); end
    step();
    checks++; if (sem_gnt !== 1'b1 || prc_gnt !== 1'b0) begin failures++; $display("FAIL sem_only_gnt got=%b%b exp=10", sem_gnt, prc_gnt); end
    checks++; if (owner !== 2'b01) begin failures++; $display("FAIL sem_only_owner got=%b exp=01", owner); end
    checks++; if (icap_i !== 32'hAA995566) begin failures++; $display("FAIL sem_only_data got=%h exp=aa995566", icap_i); end
    checks++; if ({icap_csib, icap_rdwrb} !== 2'b00) begin failures++; $display("FAIL sem_only_ctrl got=%b exp=00", {icap_csib, icap_rdwrb}); end
    // zero-latency mux: input change shows up without a clock edge
    sem_i = 32'h0BADF00D;
    #1;
    checks++; if (icap_i !== 32'h0BADF00D) begin failures++; $display("FAIL sem_only_comb got=%h exp=0badf00d", icap_i); end
  endtask

  // SEM owns on entry
  task automatic test_handover;
    prc_i = 32'h12345678; prc_csib = 1'b0; prc_rdwrb = 1'b1;
    prc_req = 1'b1;
    step();
    checks++; if ({sem_gnt, sem_rel, prc_rel} !== 3'b110) begin failures++; $display("FAIL handover_rel got=%b exp=110", {sem_gnt, sem_rel, prc_rel}); end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (sem_rel !== 1'b1 || sem_gnt !== 1'b1) begin failures++; $display("FAIL handover_hold%0d got=%b%b exp=11", k, sem_gnt, sem_rel); end
    end
    sem_req = 1'b0;
    step();
    checks++; if ({sem_gnt, sem_rel, owner, rel_timeout} !== 5'b00000) begin failures++; $display("FAIL handover_release got=%b exp=00000", {sem_gnt, sem_rel, owner, rel_timeout}); end
    checks++; if (icap_csib !== 1'b1 || icap_i !== 32'h0) begin failures++; $display("FAIL handover_gap1 csib=%b data=%h exp=1/0", icap_csib, icap_i); end
    step();
    checks++; if (icap_csib !== 1'b1 || prc_gnt !== 1'b0) begin failures++; $display("FAIL handover_gap2 csib=%b gnt=%b exp=1/0", icap_csib, prc_gnt); end
    step();
    checks++; if (prc_gnt !== 1'b0) begin failures++; $display("FAIL handover_idle gnt=%b exp=0", prc_gnt); end
    step();
    checks++; if (prc_gnt !== 1'b1 || owner !== 2'b10 || icap_i !== 32'h12345678) begin failures++; $display("FAIL handover_prc gnt=%b owner=%b data=%h exp=1/10/12345678", prc_gnt, owner, icap_i); end
  endtask

  task automatic test_withdraw;
    do_reset();
    sem_req = 1'b1;
    step();
    prc_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (sem_rel !== 1'b1) begin failures++; $display("FAIL withdraw_rel%0d got=%b exp=1", k, sem_rel); end
    end
    prc_req = 1'b0;
    step();
    checks++; if ({sem_gnt, sem_rel, owner} !== 4'b1001) begin failures++; $display("FAIL withdraw_retain got=%b exp=1001", {sem_gnt, sem_rel, owner}); end
  endtask

  // SEM owns with a freshly cleared counter on entry
  task automatic test_timeout;
    prc_req = 1'b1;
    step();
    checks++; if (sem_rel !== 1'b1) begin failures++; $display("FAIL timeout_rel_rise got=%b exp=1", sem_rel); end
    for (int k = 1; k < 16; k++) begin
      step();
      checks++; if (sem_gnt !== 1'b1 || rel_timeout !== 1'b0) begin failures++; $display("FAIL timeout_early%0d gnt=%b to=%b exp=1/0", k, sem_gnt, rel_timeout); end
    end
    step();
    checks++; if ({sem_gnt, sem_rel, rel_timeout, owner} !== 5'b00100) begin failures++; $display("FAIL timeout_revoke got=%b exp=00100", {sem_gnt, sem_rel, rel_timeout, owner}); end
    step();
    checks++; if (rel_timeout !== 1'b0 || prc_gnt !== 1'b0) begin failures++; $display("FAIL timeout_pulse to=%b gnt=%b exp=0/0", rel_timeout, prc_gnt); end
    step();
    checks++; if (prc_gnt !== 1'b0) begin failures++; $display("FAIL timeout_idle gnt=%b exp=0", prc_gnt); end
    step();
    checks++; if (prc_gnt !== 1'b1 || sem_gnt !== 1'b0 || owner !== 2'b10) begin failures++; $display("FAIL timeout_prc gnt=%b%b owner=%b exp=01/10", sem_gnt, prc_gnt, owner); end
  endtask

  task automatic test_simultaneous;
    do_reset();
    sem_req = 1'b1; prc_req = 1'b1;
    step();
    checks++; if ({sem_gnt, prc_gnt, owner} !== 4'b0110) begin failures++; $display("FAIL simul_first got=%b exp=0110", {sem_gnt, prc_gnt, owner}); end
    step();
    checks++; if ({prc_rel, sem_rel} !== 2'b10) begin failures++; $display("FAIL simul_rel got=%b exp=10", {prc_rel, sem_rel}); end
    prc_req = 1'b0;
    step();
    checks++; if ({prc_gnt, prc_rel, owner} !== 4'b0000) begin failures++; $display("FAIL simul_release got=%b exp=0000", {prc_gnt, prc_rel, owner}); end
    prc_req = 1'b1;
    step();
    step();
    step();
    checks++; if ({sem_gnt, prc_gnt, owner} !== 4'b1001) begin failures++; $display("FAIL simul_alternate got=%b exp=1001", {sem_gnt, prc_gnt, owner}); end
  endtask

  // SEM owns with PRC requesting on entry: go to REL_WAIT, then reset
  task automatic test_reset_mid;
    step();
    checks++; if (sem_rel !== 1'b1) begin failures++; $display("FAIL midrst_relwait got=%b exp=1", sem_rel); end
    icap_rst_n = 1'b0;
    #1;
    checks++; if ({sem_gnt, prc_gnt, sem_rel, prc_rel, rel_timeout} !== 5'b0) begin failures++; $display("FAIL midrst_handshake got=%b exp=00000", {sem_gnt, prc_gnt, sem_rel, prc_rel, rel_timeout}); end
    checks++; if (owner !== 2'b00 || icap_csib !== 1'b1 || icap_rdwrb !== 1'b1 || icap_i !== 32'h0) begin failures++; $display("FAIL midrst_icap owner=%b csib=%b rdwrb=%b data=%h exp=00/1/1/0", owner, icap_csib, icap_rdwrb, icap_i); end
    sem_req = 1'b0; prc_req = 1'b0;
    step();
    icap_rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sem_only();
    test_handover();
    test_withdraw();
    test_timeout();
    test_simultaneous();
    test_reset_mid();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
